// File: rtl/bus_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter_if
// Handshake bundle between the bus masters and the round-robin arbiter.
//   req_i       : per-master bus request
//   lock_i      : per-master lock (keep grant across back-to-back transfers)
//   busy_i      : addressed slave has not finished the current transfer
//   gnt_o       : one-hot registered grant
//   gnt_id_o    : index of granted master (0 when no grant)
//   gnt_valid_o : a grant is active
//   hold_o      : some requester is waiting (core pipeline hold)
//   timeout_o   : one-cycle pulse when a grant is forcibly revoked
// Modport master is the requester side, modport slave is the arbiter side.
// ---------------------------------------------------------------------------
interface bus_rr_arbiter_if #(
    parameter int NM = 4
);
    logic [NM-1:0] req_i;
    logic [NM-1:0] lock_i;
    logic          busy_i;
    logic [NM-1:0] gnt_o;
    logic [1:0]    gnt_id_o;
    logic          gnt_valid_o;
    logic          hold_o;
    logic          timeout_o;

    modport master (
        output req_i, lock_i, busy_i,
        input  gnt_o, gnt_id_o, gnt_valid_o, hold_o, timeout_o
    );

    modport slave (
        input  req_i, lock_i, busy_i,
        output gnt_o, gnt_id_o, gnt_valid_o, hold_o, timeout_o
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter
// Four-master bus arbiter: absolute priority for PRIO_MASK masters (lowest
// index first), round-robin among the rest starting after the last winner.
// A grant is held while the owner keeps requesting and is locked, the slave
// is busy, or nobody else wants the bus. A grant stuck busy for TIMEOUT+1
// cycles is revoked with a one-cycle timeout_o pulse.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous, active-low reset
//   bus : bus_rr_arbiter_if.slave (req/lock/busy in, grant/hold/timeout out)
// ---------------------------------------------------------------------------
module bus_rr_arbiter #(
    parameter int             NM        = 4,
    parameter logic [NM-1:0]  PRIO_MASK = 4'b1100,
    parameter logic [7:0]     TIMEOUT   = 8'd255
) (
    input  logic               clk,
    input  logic               rst,
    bus_rr_arbiter_if.slave    bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]    state_r;
    logic [NM-1:0] gnt_r;
    logic [1:0]    gnt_id_r;
    logic          gnt_valid_r;
    logic          tmo_r;
    logic [7:0]    busy_cnt_r;
    logic [1:0]    ptr_r;

    logic          arb_s;
    logic          tmo_s;
    logic [NM-1:0] cand_s;
    logic [NM-1:0] win_s;
    logic          own_req_s;
    logic          own_lock_s;
    logic          others_s;

    // Priority masters win outright (lowest index); otherwise search
    // ptr+1, ptr+2, ... so the last winner is considered last.
    function automatic logic [NM-1:0] pick(input logic [NM-1:0] cand,
                                           input logic [1:0]    ptr);
        logic [NM-1:0] pri;
        logic [1:0]    idx;
        pick = {NM{1'b0}};
        pri  = cand & PRIO_MASK;
        if (pri != {NM{1'b0}}) begin
            for (int i = NM - 1; i >= 0; i--) begin
                if (pri[i]) begin
                    pick = {{(NM-1){1'b0}}, 1'b1} << i;
                end
            end
        end else begin
            // Walk offsets from far to near so the nearest requester is kept.
            for (int k = NM; k >= 1; k--) begin
                idx = ptr + 2'(k);
                if (cand[idx]) begin
                    pick = {{(NM-1){1'b0}}, 1'b1} << idx;
                end
            end
        end
    endfunction

    // One-hot to index; zero (or anything malformed) encodes as 0.
    function automatic logic [1:0] enc(input logic [NM-1:0] oh);
        case (oh)
            4'b0010: enc = 2'd1;
            4'b0100: enc = 2'd2;
            4'b1000: enc = 2'd3;
            default: enc = 2'd0;
        endcase
    endfunction

    assign own_req_s  = |(bus.req_i  & gnt_r);
    assign own_lock_s = |(bus.lock_i & gnt_r);
    assign others_s   = |(bus.req_i  & ~gnt_r);

    // Decide whether to (re)arbitrate this cycle and which requesters compete.
    always_comb begin
        arb_s  = 1'b0;
        tmo_s  = 1'b0;
        cand_s = {NM{1'b0}};
        case (state_r)
            ST_IDLE: begin
                arb_s  = 1'b1;
                cand_s = bus.req_i;
            end
            ST_GRANT: begin
                if (!own_req_s) begin
                    // Owner walked away: it does not compete.
                    arb_s  = 1'b1;
                    cand_s = bus.req_i & ~gnt_r;
                end else if (bus.busy_i && (busy_cnt_r == TIMEOUT)) begin
                    // Stuck slave: revoke even if locked; owner re-wins only if alone.
                    arb_s = 1'b1;
                    tmo_s = 1'b1;
                    if (others_s) begin
                        cand_s = bus.req_i & ~gnt_r;
                    end else begin
                        cand_s = gnt_r;
                    end
                end else if (!own_lock_s && !bus.busy_i && others_s) begin
                    // Transfer boundary with contenders: owner competes again.
                    arb_s  = 1'b1;
                    cand_s = bus.req_i;
                end else begin
                    arb_s  = 1'b0;
                    cand_s = {NM{1'b0}};
                end
            end
            default: begin
                arb_s  = 1'b1;
                cand_s = {NM{1'b0}};
            end
        endcase
    end

    assign win_s = pick(cand_s, ptr_r);

    // Grant state, round-robin pointer, busy watchdog and timeout pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            gnt_r       <= {NM{1'b0}};
            gnt_id_r    <= 2'd0;
            gnt_valid_r <= 1'b0;
            tmo_r       <= 1'b0;
            busy_cnt_r  <= 8'd0;
            ptr_r       <= 2'd3;
        end else if (arb_s) begin
            gnt_r       <= win_s;
            gnt_id_r    <= enc(win_s);
            gnt_valid_r <= |win_s;
            state_r     <= (|win_s) ? ST_GRANT : ST_IDLE;
            ptr_r       <= (|win_s) ? enc(win_s) : ptr_r;
            tmo_r       <= tmo_s;
            busy_cnt_r  <= 8'd0;
        end else begin
            tmo_r       <= 1'b0;
            busy_cnt_r  <= bus.busy_i ? (busy_cnt_r + 8'd1) : 8'd0;
        end
    end

    assign bus.gnt_o       = gnt_r;
    assign bus.gnt_id_o    = gnt_id_r;
    assign bus.gnt_valid_o = gnt_valid_r;
    assign bus.timeout_o   = tmo_r;
    // Pipeline hold: a requester is waiting, or the granted transfer is stalled.
    assign bus.hold_o      = (|(bus.req_i & ~gnt_r)) | (bus.busy_i & gnt_valid_r);

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_rr_arbiter
// Directed bench for bus_rr_arbiter. Each step drives req/lock/busy/rst,
// pushes the expected post-edge outputs to a scoreboard queue, and after the
// clock edge pops and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_bus_rr_arbiter;

    logic clk;
    logic rst;

    bus_rr_arbiter_if #(.NM(4)) bus_if ();

    bus_rr_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       vld;
        logic       tmo;
        logic       hold;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string fld,
                       input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s.%s observed %0h expected %0h", tag, fld, obs, exp_v);
        end
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        chk(e.tag, "gnt",   {4'b0000, bus_if.gnt_o},       {4'b0000, e.gnt});
        chk(e.tag, "id",    {6'b000000, bus_if.gnt_id_o},  {6'b000000, e.id});
        chk(e.tag, "valid", {7'b0000000, bus_if.gnt_valid_o}, {7'b0000000, e.vld});
        chk(e.tag, "tmo",   {7'b0000000, bus_if.timeout_o},   {7'b0000000, e.tmo});
        chk(e.tag, "hold",  {7'b0000000, bus_if.hold_o},      {7'b0000000, e.hold});
    endtask

    // Drive one cycle of stimulus, queue the expected result, compare after the edge.
    task automatic apply(input logic r, input logic [3:0] req, input logic [3:0] lock,
                         input logic busy, input logic [3:0] eg, input logic [1:0] eid,
                         input logic ev, input logic et, input logic eh, input string tag);
        exp_t e;
        rst            = r;
        bus_if.req_i   = req;
        bus_if.lock_i  = lock;
        bus_if.busy_i  = busy;
        e.tag = tag; e.gnt = eg; e.id = eid; e.vld = ev; e.tmo = et; e.hold = eh;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst           = 1'b0;
        bus_if.req_i  = 4'b0000;
        bus_if.lock_i = 4'b0000;
        bus_if.busy_i = 1'b0;

        // Reset state; hold follows req alone while in reset
        apply(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, "rst_idle");
        apply(1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, "rst_req");

        // First round-robin winner is master 0, then drop req[0]
        apply(1'b1, 4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, "first_gnt");
        apply(1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, "drop0");

        // Constant 0011 alternates
        apply(1'b1, 4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, "alt_a");
        apply(1'b1, 4'b0011, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, "alt_b");
        apply(1'b1, 4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, "alt_c");

        // Priority master 3 waits for busy to clear
        apply(1'b1, 4'b1001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, "busy_hold1");
        apply(1'b1, 4'b1001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, "busy_hold2");
        apply(1'b1, 4'b1001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, "busy_hold3");
        apply(1'b1, 4'b1001, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1, "prio3_win");
        apply(1'b1, 4'b1001, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1, "prio3_keep");

        // Lowest-index priority master, then release to master 3
        apply(1'b1, 4'b1100, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1, "prio2_win");
        apply(1'b1, 4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, "prio_rel");

        // Reset mid-grant with busy, then recover with priority winner
        apply(1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, "to_m2");
        apply(1'b1, 4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1, "m2_busy");
        apply(1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, "rst_mid");
        apply(1'b1, 4'b0101, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1, "rst_recov");

        // Timeout with another requester: master 1 locked and busy
        apply(1'b1, 4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, "pre_to_a");
        apply(1'b1, 4'b0011, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, "pre_to_b");
        for (int i = 0; i < 255; i++) begin
            apply(1'b1, 4'b0011, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, "to_hold");
        end
        apply(1'b1, 4'b0011, 4'b0010, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1, "to_fire");
        apply(1'b1, 4'b0011, 4'b0010, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, "to_pulse_end");
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 4'b0011, 4'b0010, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, "to_after");
        end

        // Timeout with sole requester: re-granted to itself
        apply(1'b1, 4'b0010, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, "sole_gnt");
        for (int i = 0; i < 255; i++) begin
            apply(1'b1, 4'b0010, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, "sole_hold");
        end
        apply(1'b1, 4'b0010, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1, "sole_fire");
        apply(1'b1, 4'b0010, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, "sole_end");

        // Everyone drops: back to idle
        apply(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, "all_drop");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NM, default 4, giving the number of bus masters (fixed at 4 in this release).
REQ-002 The block SHALL have parameter PRIO_MASK, default 4'b1100, marking the absolute-priority masters (debug paths: JTAG on master 2, UART download on master 3).
REQ-003 The block SHALL have parameter TIMEOUT, default 8'd255, giving the maximum consecutive busy cycles tolerated per grant.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port req_i, input, 4 bits: per-master bus request.
REQ-007 The block SHALL have port lock_i, input, 4 bits: per-master lock, keeping the grant across back-to-back transfers.
REQ-008 The block SHALL have port busy_i, input, 1 bit: the addressed slave has not finished (e.g. I2C read ack pending).
REQ-009 The block SHALL have port gnt_o, output, 4 bits: one-hot registered grant.
REQ-010 The block SHALL have port gnt_id_o, output, 2 bits: index of the granted master, valid when gnt_valid_o=1.
REQ-011 The block SHALL have port gnt_valid_o, output, 1 bit: gnt_o is nonzero.
REQ-012 The block SHALL have port hold_o, output, 1 bit: some requesting master is not granted; drives the core pipeline hold.
REQ-013 The block SHALL have port timeout_o, output, 1 bit: one-cycle pulse when a grant is forcibly revoked.

Function
REQ-014 The block SHALL implement the FSM states IDLE (no grant) and GRANT (exactly one gnt_o bit set).
REQ-015 Arbitration SHALL select a winner as follows: if (req_i & PRIO_MASK) != 0, the lowest-index such master; otherwise round-robin, searching from index ptr+1 upward modulo 4, where ptr is the last granted index.
REQ-016 In IDLE, with any req_i bit set, the block SHALL move to GRANT and register the winner on gnt_o, gnt_id_o and gnt_valid_o, giving 1-cycle latency from req to gnt; ptr SHALL update to the winner.
REQ-017 In IDLE with req_i=0, the block SHALL stay in IDLE with gnt_o=0.
REQ-018 In GRANT, the grant SHALL be released when req_i[g]=0, or when lock_i[g]=0, busy_i=0, and another req_i bit is set.
REQ-019 In GRANT, while req_i[g]=1 and (lock_i[g]=1, busy_i=1, or no other requester), the grant SHALL be held unchanged.
REQ-020 On release, arbitration per REQ-015 SHALL use the current req_i masked by the release cause: if req_i[g]=0 the releasing master is excluded, else it competes.
REQ-021 On release, the next cycle SHALL carry the new winner's grant with no dead cycle, or IDLE with gnt_o=0 if no request remains.
REQ-022 A priority master requesting SHALL NOT preempt a grant while busy_i=1 or lock_i[g]=1; it wins at the next release.
REQ-023 An 8-bit busy counter SHALL increment each GRANT cycle with busy_i=1, clear on busy_i=0, and clear on any grant change.
REQ-024 When the busy counter equals TIMEOUT with busy_i=1, the block SHALL force a release regardless of lock_i, pulse timeout_o for exactly 1 cycle, clear the counter, and re-arbitrate excluding g unless g is the sole requester.
REQ-025 hold_o SHALL be combinational, equal to |(req_i & ~gnt_o), plus busy_i & gnt_valid_o.
REQ-026 gnt_id_o SHALL be 2'd0 when gnt_valid_o=0.
REQ-027 Simultaneous release and new request SHALL be treated as one event: the arbitration in that cycle sees all req_i bits sampled in that cycle.

Reset
REQ-028 When rst=0 at a clock edge, the block SHALL enter IDLE with gnt_o=0, gnt_id_o=0, gnt_valid_o=0, timeout_o=0, busy counter 0, and ptr=3 (so master 0 wins the first round-robin).
REQ-029 Reset asserted mid-grant or mid-timeout SHALL abandon the grant immediately with no timeout pulse; hold_o then follows req_i alone.

Verification
REQ-030 After reset, req_i=4'b0011 -> next cycle gnt_o=4'b0001, gnt_id_o=0, hold_o=1; drop req_i[0] -> next cycle gnt_o=4'b0010.
REQ-031 req_i=4'b0011 held constant with lock=0, busy=0 -> gnt_o alternates 0001, 0010, 0001 on successive cycles.
REQ-032 Master 0 granted with busy_i=1; raise req_i[3] -> gnt_o stays 0001 until busy_i=0, then gnt_o=4'b1000 next cycle.
REQ-033 Master 1 granted, lock_i[1]=1, busy_i=1 for 300 cycles -> timeout_o pulses once 256 cycles after busy_i rose; gnt_o moves to the other requester, or is re-granted to 0010 if master 1 is alone.
REQ-034 req_i=4'b1100 -> gnt_o=4'b0100 (lowest-index priority master); release -> gnt_o=4'b1000.
REQ-035 rst=0 while gnt_o=4'b0100 and busy_i=1 -> next cycle gnt_o=0, timeout_o=0; rst=1 with req_i=4'b0101 -> gnt_o=4'b0100.
